alu_op_issue: RTL

- Sequencing stage directly upstream of the team's 74181-style alu. It feeds the alu and also consumes what the alu produces.
- Accepts a DLX ALU operation and two operands over a valid/ready handshake, then decodes the operation into the alu control lines M, S3..S0 and C0.
- Holds the alu inputs stable while the alu settles, captures F and COUT, and post-processes DLX set-compare ops into 0/1 results.
- Returns the result over a second valid/ready handshake. Sits between the DLX ID/EX register and the EX/MEM register.

---
 rtl/alu_op_issue_if.sv | 33 +++
 rtl/alu_op_issue.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/alu_op_issue_if.sv
// Handshake and alu-side signal bundle for alu_op_issue.
// The master side is the environment (ID/EX, EX/MEM and the alu); the slave side is the issue stage.
interface alu_op_issue_if #(
  parameter int unsigned N = 32
);
  logic         IN_VALID;
  logic         IN_READY;
  logic [3:0]   OP;
  logic [N-1:0] OPA;
  logic [N-1:0] OPB;
  logic [N-1:0] ALU_A;
  logic [N-1:0] ALU_B;
  logic         ALU_C0;
  logic         ALU_M;
  logic [3:0]   ALU_S;
  logic [N-1:0] ALU_F;
  logic         ALU_COUT;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [N-1:0] RESULT;
  logic         OVF;
  logic         ILLEGAL;

  modport master (
    output IN_VALID, OP, OPA, OPB, ALU_F, ALU_COUT, OUT_READY,
    input  IN_READY, ALU_A, ALU_B, ALU_C0, ALU_M, ALU_S, OUT_VALID, RESULT, OVF, ILLEGAL
  );

  modport slave (
    input  IN_VALID, OP, OPA, OPB, ALU_F, ALU_COUT, OUT_READY,
    output IN_READY, ALU_A, ALU_B, ALU_C0, ALU_M, ALU_S, OUT_VALID, RESULT, OVF, ILLEGAL
  );
endinterface

// File: rtl/alu_op_issue.sv
// DLX ALU op issue stage: decodes ops onto 74181-style controls, holds the alu
// inputs for one settle cycle, then returns the (compare-post-processed) result.
module alu_op_issue #(
  parameter int unsigned N = 32
) (
  input logic         CLK,
  input logic         RST_N,
  alu_op_issue_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_PASSB = 4'd5,
    OP_SEQ   = 4'd8,
    OP_SNE   = 4'd9,
    OP_SLT   = 4'd10,
    OP_SGT   = 4'd11,
    OP_SLE   = 4'd12,
    OP_SGE   = 4'd13
  } op_t;

  state_t       state, state_d;
  logic [3:0]   op_q, op_d;
  logic [N-1:0] alu_a_d, alu_b_d, result_d;
  logic [3:0]   alu_s_d;
  logic         alu_m_d, alu_c0_d, ovf_d, illegal_d, out_valid_d, in_ready_d;
  logic         cmp_bit;

  logic f_zero, f_neg, sub_v, lt, add_v;

  // Overflow terms use the latched operand copies still sitting on ALU_A/ALU_B.
  assign f_zero = (bus.ALU_F == '0);
  assign f_neg  = bus.ALU_F[N-1];
  assign sub_v  = (bus.ALU_A[N-1] != bus.ALU_B[N-1]) & (bus.ALU_F[N-1] != bus.ALU_A[N-1]);
  assign add_v  = (bus.ALU_A[N-1] == bus.ALU_B[N-1]) & (bus.ALU_F[N-1] != bus.ALU_A[N-1]);
  assign lt     = f_neg ^ sub_v;

  always_comb begin
    state_d     = state;
    op_d        = op_q;
    alu_a_d     = bus.ALU_A;
    alu_b_d     = bus.ALU_B;
    alu_s_d     = bus.ALU_S;
    alu_m_d     = bus.ALU_M;
    alu_c0_d    = bus.ALU_C0;
    result_d    = bus.RESULT;
    ovf_d       = bus.OVF;
    illegal_d   = bus.ILLEGAL;
    out_valid_d = bus.OUT_VALID;
    in_ready_d  = bus.IN_READY;
    cmp_bit     = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.IN_VALID) begin
          op_d       = bus.OP;
          alu_a_d    = bus.OPA;
          alu_b_d    = bus.OPB;
          in_ready_d = 1'b0;
          state_d    = SETTLE;
          case (bus.OP)
            OP_ADD:   begin alu_m_d = 1'b0; alu_s_d = 4'b1001; alu_c0_d = 1'b0; end
            OP_SUB, OP_SEQ, OP_SNE, OP_SLT, OP_SGT, OP_SLE, OP_SGE:
                      begin alu_m_d = 1'b0; alu_s_d = 4'b0110; alu_c0_d = 1'b1; end
            OP_AND:   begin alu_m_d = 1'b1; alu_s_d = 4'b1011; alu_c0_d = 1'b0; end
            OP_OR:    begin alu_m_d = 1'b1; alu_s_d = 4'b1110; alu_c0_d = 1'b0; end
            OP_XOR:   begin alu_m_d = 1'b1; alu_s_d = 4'b0110; alu_c0_d = 1'b0; end
            default:  begin alu_m_d = 1'b1; alu_s_d = 4'b1010; alu_c0_d = 1'b0; end
          endcase
        end
      end

      SETTLE: begin
        result_d    = bus.ALU_F;
        ovf_d       = 1'b0;
        illegal_d   = 1'b0;
        out_valid_d = 1'b1;
        state_d     = HOLD;
        case (op_q)
          OP_ADD: ovf_d = add_v;
          OP_SUB: ovf_d = sub_v;
          OP_AND, OP_OR, OP_XOR, OP_PASSB: ;
          OP_SEQ, OP_SNE, OP_SLT, OP_SGT, OP_SLE, OP_SGE: begin
            case (op_q)
              OP_SEQ:  cmp_bit = f_zero;
              OP_SNE:  cmp_bit = !f_zero;
              OP_SLT:  cmp_bit = lt;
              OP_SGT:  cmp_bit = !lt & !f_zero;
              OP_SLE:  cmp_bit = lt | f_zero;
              default: cmp_bit = !lt;
            endcase
            result_d    = '0;
            result_d[0] = cmp_bit;
          end
          default: begin
            result_d  = '0;
            illegal_d = 1'b1;
          end
        endcase
      end

      HOLD: begin
        if (bus.OUT_READY) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= IDLE;
      op_q          <= '0;
      bus.IN_READY  <= 1'b1;
      bus.OUT_VALID <= 1'b0;
      bus.RESULT    <= '0;
      bus.OVF       <= 1'b0;
      bus.ILLEGAL   <= 1'b0;
      bus.ALU_A     <= '0;
      bus.ALU_B     <= '0;
      bus.ALU_S     <= '0;
      bus.ALU_M     <= 1'b1;
      bus.ALU_C0    <= 1'b0;
    end else begin
      state         <= state_d;
      op_q          <= op_d;
      bus.IN_READY  <= in_ready_d;
      bus.OUT_VALID <= out_valid_d;
      bus.RESULT    <= result_d;
      bus.OVF       <= ovf_d;
      bus.ILLEGAL   <= illegal_d;
      bus.ALU_A     <= alu_a_d;
      bus.ALU_B     <= alu_b_d;
      bus.ALU_S     <= alu_s_d;
      bus.ALU_M     <= alu_m_d;
      bus.ALU_C0    <= alu_c0_d;
    end
  end

endmodule
